// File: rtl/pc_sequencer_if.sv
// Fetch / issue / execute handshake bundle between the PC sequencer and its environment.
interface pc_sequencer_if #(
  parameter int unsigned CNT_W = 32
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned IW   = 32;

  // instruction memory fetch channel
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ack;
  logic [IW-1:0]    imem_data;

  // issue to datapath
  logic             instr_valid;
  logic [IW-1:0]    instr;

  // datapath resolution
  logic             exec_done;
  logic             Branch;
  logic             Uncondbranch;
  logic             ALUZero;
  logic [XLEN-1:0]  SignExtImm64;

  // flow control and architectural status
  logic             stall;
  logic [XLEN-1:0]  CurrentPC;
  logic [CNT_W-1:0] retired;
  logic             taken;

  // environment side: memory, datapath and stall source
  modport master (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  instr_valid,
    input  instr,
    output exec_done,
    output Branch,
    output Uncondbranch,
    output ALUZero,
    output SignExtImm64,
    output stall,
    input  CurrentPC,
    input  retired,
    input  taken
  );

  // sequencer side
  modport slave (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output instr_valid,
    output instr,
    input  exec_done,
    input  Branch,
    input  Uncondbranch,
    input  ALUZero,
    input  SignExtImm64,
    input  stall,
    output CurrentPC,
    output retired,
    output taken
  );

endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: fetch, issue, wait for execute, update PC.
// Every output is a register; imem_addr is the PC register itself.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input logic           CLK,
  input logic           resetl,
  pc_sequencer_if.slave bus
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned IW   = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4
  } state_t;

  // Branch controls and offset captured when the datapath resolves.
  typedef struct packed {
    logic            branch;
    logic            uncond;
    logic            zero;
    logic [XLEN-1:0] imm;
  } exec_op_t;

  function automatic logic redirect_f(input exec_op_t op);
    return op.uncond | (op.branch & op.zero);
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       rst_sync_q;
  logic             run_ok_c;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [IW-1:0]    instr_q, instr_d;
  exec_op_t         ops_q, ops_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic             taken_q, taken_d;

  // Reset release synchroniser: the FSM leaves IDLE only once it reads 1.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_ok_c = rst_sync_q[1];

  // State and output registers.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      retired_q     <= '0;
      instr_q       <= '0;
      ops_q         <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      retired_q     <= retired_d;
      instr_q       <= instr_d;
      ops_q         <= ops_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      taken_q       <= taken_d;
    end
  end

  // Next state, datapath next values and next registered outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    instr_d   = instr_q;
    ops_d     = ops_q;

    case (state_q)
      IDLE: begin
        // stall is only honoured here; in-flight work always completes
        if (run_ok_c && !bus.stall) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (bus.exec_done) begin
          ops_d.branch = bus.Branch;
          ops_d.uncond = bus.Uncondbranch;
          ops_d.zero   = bus.ALUZero;
          ops_d.imm    = bus.SignExtImm64;
          state_d      = UPDATE;
        end
      end
      UPDATE: begin
        // word offset scaled to bytes; bits shifted past bit 63 are dropped
        if (redirect_f(ops_q)) begin
          pc_d = pc_q + {ops_q.imm[XLEN-3:0], 2'b00};
        end else begin
          pc_d = pc_q + XLEN'(4);
        end
        retired_d = retired_q + CNT_W'(1);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // registered strobes follow the state being entered
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == ISSUE);
    taken_d       = (state_d == UPDATE) && redirect_f(ops_d);
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.CurrentPC   = pc_q;
  assign bus.retired     = retired_q;
  assign bus.taken       = taken_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a transaction-level PC / retire model.
module tb_pc_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int unsigned CNT_W    = 32;
  localparam int          PERIOD   = 10;

  logic CLK    = 1'b0;
  logic resetl = 1'b0;

  pc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pc_sequencer #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus)
  );

  always #(PERIOD / 2) CLK = ~CLK;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // architectural model: PC and retired count
  logic [63:0]      m_pc  = RESET_PC;
  logic [CNT_W-1:0] m_ret = '0;

  task automatic junk_branch_inputs();
    bus.Branch       = 1'($urandom);
    bus.Uncondbranch = 1'($urandom);
    bus.ALUZero      = 1'($urandom);
    bus.SignExtImm64 = {$urandom, $urandom};
  endtask

  // One full instruction from fetch to the following IDLE, checked at every phase.
  task automatic run_instr(input logic b, input logic ub, input logic z, input logic [63:0] imm,
                           input int ack_dly, input int ex_dly, input int stall_cyc,
                           input bit spurious, input bit rand_stall, output time t_fetch);
    logic [31:0] word;
    logic [63:0] addr0;
    logic        exp_taken;
    int          n;
    word      = $urandom;
    exp_taken = ub | (b & z);
    n = 0;
    t_fetch = $time;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    t_fetch = $time;
    chk_cnt++;
    if (bus.imem_req !== 1'b1) begin
      $display("FAIL fetch_start_timeout imem_req=%b expected 1", bus.imem_req);
      return;
    end else pass_cnt++;
    chk_cnt++;
    if (bus.imem_addr !== m_pc) $display("FAIL fetch_addr got %h expected %h", bus.imem_addr, m_pc);
    else pass_cnt++;
    addr0 = bus.imem_addr;
    for (int i = 0; i < ack_dly; i++) begin
      if (rand_stall) bus.stall = 1'($urandom);
      if (spurious && i == 0) bus.exec_done = 1'b1;
      junk_branch_inputs();
      @(negedge CLK);
      bus.exec_done = 1'b0;
      chk_cnt++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== addr0 || bus.instr_valid !== 1'b0)
        $display("FAIL fetch_wait cyc=%0d req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                 i, bus.imem_req, bus.imem_addr, bus.instr_valid, addr0);
      else pass_cnt++;
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    @(negedge CLK);
    bus.imem_ack  = 1'b0;
    bus.imem_data = $urandom;
    chk_cnt++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== word || bus.imem_req !== 1'b0)
      $display("FAIL issue valid=%b instr=%h req=%b expected valid=1 instr=%h req=0",
               bus.instr_valid, bus.instr, bus.imem_req, word);
    else pass_cnt++;
    @(negedge CLK);
    chk_cnt++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0)
      $display("FAIL exec_entry valid=%b req=%b expected 0 0", bus.instr_valid, bus.imem_req);
    else pass_cnt++;
    for (int i = 0; i < ex_dly; i++) begin
      if (rand_stall) bus.stall = 1'($urandom);
      if (spurious && i == 0) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = ~word;
      end
      junk_branch_inputs();
      @(negedge CLK);
      bus.imem_ack = 1'b0;
      chk_cnt++;
      if (bus.instr_valid !== 1'b0 || bus.taken !== 1'b0 || bus.instr !== word || bus.imem_req !== 1'b0)
        $display("FAIL exec_wait cyc=%0d valid=%b taken=%b instr=%h req=%b expected 0 0 %h 0",
                 i, bus.instr_valid, bus.taken, bus.instr, bus.imem_req, word);
      else pass_cnt++;
    end
    bus.exec_done    = 1'b1;
    bus.Branch       = b;
    bus.Uncondbranch = ub;
    bus.ALUZero      = z;
    bus.SignExtImm64 = imm;
    @(negedge CLK);
    bus.exec_done = 1'b0;
    junk_branch_inputs();
    bus.stall = (stall_cyc > 0);
    chk_cnt++;
    if (bus.taken !== exp_taken) $display("FAIL update_taken got %b expected %b", bus.taken, exp_taken);
    else pass_cnt++;
    m_pc  = exp_taken ? m_pc + (imm << 2) : m_pc + 64'd4;
    m_ret = m_ret + 1'b1;
    @(negedge CLK);
    chk_cnt++;
    if (bus.CurrentPC !== m_pc || bus.retired !== m_ret || bus.taken !== 1'b0 || bus.imem_req !== 1'b0)
      $display("FAIL idle_state pc=%h ret=%0d taken=%b req=%b expected pc=%h ret=%0d taken=0 req=0",
               bus.CurrentPC, bus.retired, bus.taken, bus.imem_req, m_pc, m_ret);
    else pass_cnt++;
    for (int i = 0; i < stall_cyc; i++) begin
      chk_cnt++;
      if (bus.imem_req !== 1'b0) $display("FAIL stall_hold cyc=%0d req=%b expected 0", i, bus.imem_req);
      else pass_cnt++;
      if (i == stall_cyc - 1) bus.stall = 1'b0;
      @(negedge CLK);
    end
  endtask

  // Redirect the model and DUT to an arbitrary word-aligned PC via an unconditional branch.
  task automatic goto_pc(input logic [63:0] target);
    time t;
    run_instr(1'b0, 1'b1, 1'b0, (target - m_pc) >> 2, 0, 0, 0, 1'b0, 1'b0, t);
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    repeat (3) @(negedge CLK);
    chk_cnt++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.taken !== 1'b0 ||
        bus.CurrentPC !== RESET_PC || bus.retired !== '0 || bus.instr !== 32'h0)
      $display("FAIL reset_state req=%b valid=%b taken=%b pc=%h ret=%0d instr=%h expected 0 0 0 %h 0 0",
               bus.imem_req, bus.instr_valid, bus.taken, bus.CurrentPC, bus.retired, bus.instr, RESET_PC);
    else pass_cnt++;
    resetl = 1'b1;
    @(negedge CLK);
    chk_cnt++;
    if (bus.imem_req !== 1'b0) $display("FAIL reset_sync_first_edge req=%b expected 0", bus.imem_req);
    else pass_cnt++;
    m_pc  = RESET_PC;
    m_ret = '0;
  endtask

  task automatic test_sequential();
    time t_prev, t_cur;
    run_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 0, 1'b0, 1'b0, t_prev);
    for (int k = 0; k < 3; k++) begin
      run_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 0, 1'b0, 1'b0, t_cur);
      chk_cnt++;
      if (t_cur - t_prev !== time'(5 * PERIOD))
        $display("FAIL seq_latency got %0t expected %0t", t_cur - t_prev, time'(5 * PERIOD));
      else pass_cnt++;
      t_prev = t_cur;
    end
    chk_cnt++;
    if (bus.CurrentPC !== 64'd16 || bus.retired !== CNT_W'(4))
      $display("FAIL seq_final pc=%h ret=%0d expected 10 4", bus.CurrentPC, bus.retired);
    else pass_cnt++;
  endtask

  task automatic test_cond_branch();
    time t;
    goto_pc(64'h100);
    run_instr(1'b1, 1'b0, 1'b1, 64'h10, 0, 0, 0, 1'b0, 1'b0, t);
    chk_cnt++;
    if (bus.CurrentPC !== 64'h140) $display("FAIL cond_taken pc=%h expected 140", bus.CurrentPC);
    else pass_cnt++;
    goto_pc(64'h100);
    run_instr(1'b1, 1'b0, 1'b0, 64'h10, 0, 0, 0, 1'b0, 1'b0, t);
    chk_cnt++;
    if (bus.CurrentPC !== 64'h104) $display("FAIL cond_not_taken pc=%h expected 104", bus.CurrentPC);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    time t;
    goto_pc(64'h8);
    run_instr(1'b0, 1'b1, 1'b0, -64'sd4, 0, 0, 0, 1'b0, 1'b0, t);
    chk_cnt++;
    if (bus.CurrentPC !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL backward_wrap pc=%h expected fffffffffffffff8", bus.CurrentPC);
    else pass_cnt++;
    goto_pc(64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 0, 1'b0, 1'b0, t);
    chk_cnt++;
    if (bus.CurrentPC !== 64'h0) $display("FAIL seq_wrap pc=%h expected 0", bus.CurrentPC);
    else pass_cnt++;
  endtask

  task automatic test_slow_and_stall();
    time t;
    run_instr(1'b0, 1'b0, 1'b0, 64'h0, 7, 2, 4, 1'b0, 1'b0, t);
    @(negedge CLK);
    chk_cnt++;
    if (bus.imem_req !== 1'b1) $display("FAIL stall_release req=%b expected 1", bus.imem_req);
    else pass_cnt++;
    run_instr(1'b1, 1'b0, 1'b1, 64'h3, 1, 1, 0, 1'b0, 1'b0, t);
  endtask

  task automatic test_spurious();
    time t;
    run_instr(1'b0, 1'b0, 1'b0, 64'h0, 3, 3, 0, 1'b1, 1'b0, t);
    run_instr(1'b0, 1'b1, 1'b0, 64'h20, 2, 2, 1, 1'b1, 1'b1, t);
  endtask

  task automatic test_reset_mid();
    time t;
    int  n;
    // reset while fetching, with an ack arriving during reset
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    resetl = 1'b0;
    #1;
    chk_cnt++;
    if (bus.imem_req !== 1'b0 || bus.CurrentPC !== RESET_PC || bus.retired !== '0)
      $display("FAIL reset_in_fetch req=%b pc=%h ret=%0d expected 0 %h 0", bus.imem_req, bus.CurrentPC, bus.retired, RESET_PC);
    else pass_cnt++;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    bus.imem_ack = 1'b0;
    chk_cnt++;
    if (bus.instr !== 32'h0 || bus.instr_valid !== 1'b0)
      $display("FAIL reset_ack_discard instr=%h valid=%b expected 0 0", bus.instr, bus.instr_valid);
    else pass_cnt++;
    resetl = 1'b1;
    m_pc  = RESET_PC;
    m_ret = '0;
    bus.exec_done = 1'b1;
    @(negedge CLK);
    bus.exec_done = 1'b0;
    run_instr(1'b0, 1'b0, 1'b0, 64'h0, 1, 0, 0, 1'b0, 1'b0, t);
    // reset while executing, with exec_done arriving during reset
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = $urandom;
    @(negedge CLK);
    bus.imem_ack = 1'b0;
    @(negedge CLK);
    resetl = 1'b0;
    #1;
    chk_cnt++;
    if (bus.imem_req !== 1'b0 || bus.taken !== 1'b0 || bus.instr !== 32'h0 ||
        bus.CurrentPC !== RESET_PC || bus.retired !== '0)
      $display("FAIL reset_in_exec req=%b taken=%b instr=%h pc=%h ret=%0d expected 0 0 0 %h 0",
               bus.imem_req, bus.taken, bus.instr, bus.CurrentPC, bus.retired, RESET_PC);
    else pass_cnt++;
    bus.exec_done    = 1'b1;
    bus.Uncondbranch = 1'b1;
    @(negedge CLK);
    resetl = 1'b1;
    @(negedge CLK);
    bus.exec_done = 1'b0;
    chk_cnt++;
    if (bus.taken !== 1'b0 || bus.CurrentPC !== RESET_PC || bus.retired !== '0)
      $display("FAIL late_exec_done taken=%b pc=%h ret=%0d expected 0 %h 0", bus.taken, bus.CurrentPC, bus.retired, RESET_PC);
    else pass_cnt++;
    m_pc  = RESET_PC;
    m_ret = '0;
    run_instr(1'b0, 1'b0, 1'b0, 64'h0, 0, 0, 0, 1'b0, 1'b0, t);
  endtask

  task automatic test_random();
    time         t;
    logic [63:0] imm;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0) imm = {$urandom, $urandom};
      else imm = 64'($signed($urandom_range(0, 511)) - 256);
      run_instr(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), imm,
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2),
                1'($urandom), 1'b1, t);
    end
  endtask

  initial begin
    bus.imem_ack     = 1'b0;
    bus.imem_data    = '0;
    bus.exec_done    = 1'b0;
    bus.Branch       = 1'b0;
    bus.Uncondbranch = 1'b0;
    bus.ALUZero      = 1'b0;
    bus.SignExtImm64 = '0;
    bus.stall        = 1'b0;
    test_reset();
    test_sequential();
    test_cond_branch();
    test_wrap();
    test_slow_and_stall();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
